cache_state_ram: RTL and testbench

//  Parametrised per-set state store for set-associative ao486 caches: MSI bits per way plus tree-pLRU bits per set.

---
 rtl/cache_state_ram_if.sv | 51 +++++
 rtl/cache_state_ram.sv | 171 +++++++++++++++++
 tb/tb_cache_state_ram.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_state_ram_if.sv
// Bundle between the cache FSM / line RAMs and the set state store.
// master = cache side and memory path, slave = cache_state_ram.
interface cache_state_ram_if #(
  parameter int WAYS      = 4,
  parameter int SETS_LOG2 = 8,
  parameter int LINE_LOG2 = 4,
  parameter int TAG_W     = 20
);
  localparam int CW    = 3*WAYS-1;
  localparam int LB    = 8 << LINE_LOG2;
  localparam int WAY_W = $clog2(WAYS);

  logic [31:0]          address;
  logic                 read_do;
  logic                 write_do;
  logic [CW-1:0]        data;
  logic [CW-1:0]        q;
  logic                 busy;
  logic                 invd_do;
  logic                 invd_done;
  logic                 wbinvd_do;
  logic                 wbinvd_done;
  logic                 wb_do;
  logic                 wb_done;
  logic                 line_rd_do;
  logic [SETS_LOG2-1:0] line_rd_set;
  logic [WAY_W-1:0]     line_rd_way;
  logic [TAG_W+LB-1:0]  line_rd_q;
  logic                 writeline_do;
  logic                 writeline_done;
  logic [31:0]          writeline_address;
  logic [LB-1:0]        writeline_line;

  modport master (
    output address, read_do, write_do, data,
    output invd_do, wbinvd_do, wb_do,
    output line_rd_q, writeline_done,
    input  q, busy, invd_done, wbinvd_done, wb_done,
    input  line_rd_do, line_rd_set, line_rd_way,
    input  writeline_do, writeline_address, writeline_line
  );

  modport slave (
    input  address, read_do, write_do, data,
    input  invd_do, wbinvd_do, wb_do,
    input  line_rd_q, writeline_done,
    output q, busy, invd_done, wbinvd_done, wb_done,
    output line_rd_do, line_rd_set, line_rd_way,
    output writeline_do, writeline_address, writeline_line
  );
endinterface

// File: rtl/cache_state_ram.sv
// Per-set MSI + tree-pLRU state store with init, invalidate,
// write-back-invalidate and write-back-only sweeps.
module cache_state_ram #(
  parameter int WAYS      = 4,
  parameter int SETS_LOG2 = 8,
  parameter int LINE_LOG2 = 4,
  parameter int TAG_W     = 20
) (
  input logic              clk,
  input logic              rst_n,
  cache_state_ram_if.slave bus
);
  localparam int CW    = 3*WAYS-1;
  localparam int LB    = 8 << LINE_LOG2;
  localparam int WAY_W = $clog2(WAYS);
  localparam int SETS  = 1 << SETS_LOG2;

  typedef enum logic [2:0] {
    IDLE, INIT, INVD, SW_RD, SW_EVAL
  } state_t;

  state_t               state_q, state_d;
  logic [SETS_LOG2-1:0] set_cnt_q, set_cnt_d;
  logic [SETS_LOG2-1:0] last_set_q, last_set_d;
  logic [WAY_W-1:0]     way_cnt_q, way_cnt_d;
  logic                 wb_mode_q, wb_mode_d;
  logic                 end_q, end_d;
  logic                 first_q, first_d;
  logic [TAG_W+LB-1:0]  hold_q, hold_d;

  logic [CW-1:0]        mem_q [SETS];
  logic                 mem_we;
  logic [SETS_LOG2-1:0] mem_wa;
  logic [CW-1:0]        mem_wd;
  logic [SETS_LOG2-1:0] acc_set, rd_addr;
  logic [CW-1:0]        rd_word, clean_word;
  logic [1:0]           msi;
  logic [TAG_W+LB-1:0]  line_cur;
  logic                 start, dirty, adv;
  logic                 way_last, set_last;
  logic                 addr_unused;

  assign acc_set  = bus.address[LINE_LOG2 +: SETS_LOG2];
  assign rd_addr  = (state_q == IDLE) ? last_set_q : set_cnt_q;
  assign rd_word  = mem_q[rd_addr];
  assign way_last = (way_cnt_q == WAY_W'(WAYS-1));
  assign set_last = &set_cnt_q;
  assign start    = (state_q == IDLE) &&
                    (bus.invd_do || bus.wbinvd_do || bus.wb_do);
  // Line RAM output is only guaranteed one cycle; hold it for stalls.
  assign line_cur = first_q ? bus.line_rd_q : hold_q;
  assign addr_unused = ^{bus.address[31:LINE_LOG2+SETS_LOG2],
                         bus.address[LINE_LOG2-1:0]};

  always_comb begin
    msi = 2'b00;
    clean_word = rd_word;
    for (int i = 0; i < WAYS; i++) begin
      if (way_cnt_q == WAY_W'(i)) msi = rd_word[2*i +: 2];
      clean_word[2*i+1] = 1'b0;
    end
    dirty = (msi == 2'b11);
  end

  always_comb begin
    state_d    = state_q;
    set_cnt_d  = set_cnt_q;
    way_cnt_d  = way_cnt_q;
    wb_mode_d  = wb_mode_q;
    last_set_d = bus.read_do ? acc_set : last_set_q;
    first_d    = (state_q == SW_RD);
    hold_d     = line_cur;
    mem_we     = 1'b0;
    mem_wa     = set_cnt_q;
    mem_wd     = '0;
    adv        = 1'b0;
    bus.invd_done    = 1'b0;
    bus.wbinvd_done  = 1'b0;
    bus.wb_done      = 1'b0;
    bus.line_rd_do   = 1'b0;
    bus.writeline_do = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.invd_do) begin
          state_d = INVD;
        end else if (bus.wbinvd_do) begin
          state_d   = SW_RD;
          wb_mode_d = 1'b0;
        end else if (bus.wb_do) begin
          state_d   = SW_RD;
          wb_mode_d = 1'b1;
        end else if (bus.write_do) begin
          mem_we = 1'b1;
          mem_wa = acc_set;
          mem_wd = bus.data;
        end
      end
      INIT, INVD: begin
        mem_we = 1'b1;
        if (set_last) begin
          state_d       = IDLE;
          set_cnt_d     = '0;
          bus.invd_done = (state_q == INVD);
        end else begin
          set_cnt_d = set_cnt_q + 1'b1;
        end
      end
      SW_RD: begin
        bus.line_rd_do = 1'b1;
        state_d        = SW_EVAL;
      end
      SW_EVAL: begin
        bus.writeline_do = dirty;
        adv = !dirty || bus.writeline_done;
        if (adv && way_last) begin
          mem_we    = 1'b1;
          mem_wd    = wb_mode_q ? clean_word : '0;
          way_cnt_d = '0;
          if (set_last) begin
            state_d         = IDLE;
            set_cnt_d       = '0;
            bus.wb_done     = wb_mode_q;
            bus.wbinvd_done = !wb_mode_q;
          end else begin
            state_d   = SW_RD;
            set_cnt_d = set_cnt_q + 1'b1;
          end
        end else if (adv) begin
          state_d   = SW_RD;
          way_cnt_d = way_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    end_d = (state_q != IDLE) && (state_d == IDLE);
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.q           = (bus.busy || start || end_q) ? '0 : rd_word;
  assign bus.line_rd_set = set_cnt_q;
  assign bus.line_rd_way = way_cnt_q;
  assign bus.writeline_line    = line_cur[LB-1:0];
  assign bus.writeline_address = {line_cur[LB +: TAG_W], set_cnt_q,
                                  {LINE_LOG2{1'b0}}};

  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem_q[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= INIT;
      set_cnt_q  <= '0;
      last_set_q <= '0;
      way_cnt_q  <= '0;
      wb_mode_q  <= 1'b0;
      end_q      <= 1'b0;
      first_q    <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      set_cnt_q  <= set_cnt_d;
      last_set_q <= last_set_d;
      way_cnt_q  <= way_cnt_d;
      wb_mode_q  <= wb_mode_d;
      end_q      <= end_d;
      first_q    <= first_d;
      hold_q     <= hold_d;
    end
  end
endmodule

// File: tb/tb_cache_state_ram.sv
// Directed bench for cache_state_ram: init, read/write, bypass,
// invd/wbinvd/wb sweeps, start priority and reset mid-sweep.
module tb_cache_state_ram;
  localparam int WAYS = 4, SETS_LOG2 = 8, LINE_LOG2 = 4, TAG_W = 20;
  localparam int CW = 11, LB = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0, errors = 0;
  int n_wl = 0, n_invd = 0, n_wbinvd = 0, n_wb = 0;
  logic [31:0] wl_addr;
  logic [LB-1:0] wl_line;

  always #5 clk = ~clk;

  cache_state_ram_if #(.WAYS(WAYS), .SETS_LOG2(SETS_LOG2),
    .LINE_LOG2(LINE_LOG2), .TAG_W(TAG_W)) bus ();

  cache_state_ram #(.WAYS(WAYS), .SETS_LOG2(SETS_LOG2),
    .LINE_LOG2(LINE_LOG2), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  function automatic logic [TAG_W-1:0] tag_of(
    input logic [7:0] s, input logic [1:0] w);
    return (s == 8'd3 && w == 2'd2) ? 20'hABCDE : {12'h123, s};
  endfunction

  always @(posedge clk)
    if (bus.line_rd_do)
      bus.line_rd_q <= {tag_of(bus.line_rd_set, bus.line_rd_way),
        {8{bus.line_rd_set, 6'b0, bus.line_rd_way}}};

  always @(negedge clk) begin
    if (bus.writeline_do && bus.writeline_done) begin
      n_wl++;
      wl_addr = bus.writeline_address;
      wl_line = bus.writeline_line;
    end
    if (bus.invd_done) n_invd++;
    if (bus.wbinvd_done) n_wbinvd++;
    if (bus.wb_done) n_wb++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] set_addr(input logic [7:0] s);
    return {20'hFFFFF, s, 4'hF};
  endfunction

  task automatic read_set(input logic [7:0] s);
    bus.address = set_addr(s);
    bus.read_do = 1'b1;
    tick();
    bus.read_do = 1'b0;
  endtask

  task automatic write_set(input logic [7:0] s, input logic [CW-1:0] d);
    bus.address  = set_addr(s);
    bus.data     = d;
    bus.write_do = 1'b1;
    tick();
    bus.write_do = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy && n < 3000) begin
      tick();
      n++;
    end
  endtask

  task automatic run_sweep(output int cyc);
    int hold;
    logic [31:0] a0;
    hold = 0;
    cyc = 0;
    a0 = '0;
    while (bus.busy && cyc < 4000) begin
      tick();
      cyc++;
      bus.writeline_done = 1'b0;
      if (bus.writeline_do) begin
        if (hold == 0) a0 = bus.writeline_address;
        else begin
          checks++;
          if (bus.writeline_address !== a0) begin
            errors++;
            $display("FAIL wl_hold addr=%h exp=%h",
              bus.writeline_address, a0);
          end
        end
        hold++;
        if (hold == 3) begin
          bus.writeline_done = 1'b1;
          hold = 0;
        end
      end
    end
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.busy !== 1'b1 || bus.writeline_do !== 1'b0 ||
        bus.line_rd_do !== 1'b0 || bus.q !== '0) begin
      errors++;
      $display("FAIL reset busy=%b wl=%b rd=%b q=%h exp 1 0 0 0",
        bus.busy, bus.writeline_do, bus.line_rd_do, bus.q);
    end
    rst_n = 1'b1;
    wait_idle(n);
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL init_len cycles=%0d exp=256", n);
    end
    read_set(8'd7);
    checks++;
    if (bus.q !== 11'h000) begin
      errors++;
      $display("FAIL init_rd7 q=%h exp=000", bus.q);
    end
    read_set(8'd255);
    checks++;
    if (bus.q !== 11'h000) begin
      errors++;
      $display("FAIL init_rd255 q=%h exp=000", bus.q);
    end
  endtask

  task automatic test_write_read();
    write_set(8'd5, 11'h0D7);
    read_set(8'd5);
    checks++;
    if (bus.q !== 11'h0D7) begin
      errors++;
      $display("FAIL rd5 q=%h exp=0D7", bus.q);
    end
    tick();
    write_set(8'd9, 11'h2A5);
    tick();
    checks++;
    if (bus.q !== 11'h0D7) begin
      errors++;
      $display("FAIL q_stable q=%h exp=0D7", bus.q);
    end
    read_set(8'd9);
    checks++;
    if (bus.q !== 11'h2A5) begin
      errors++;
      $display("FAIL rd9 q=%h exp=2A5", bus.q);
    end
  endtask

  task automatic test_back_to_back();
    write_set(8'd6, 11'h5A3);
    read_set(8'd6);
    checks++;
    if (bus.q !== 11'h5A3) begin
      errors++;
      $display("FAIL bypass6 q=%h exp=5A3", bus.q);
    end
    bus.address  = set_addr(8'd10);
    bus.data     = 11'h13C;
    bus.write_do = 1'b1;
    bus.read_do  = 1'b1;
    tick();
    bus.write_do = 1'b0;
    bus.read_do  = 1'b0;
    checks++;
    if (bus.q !== 11'h13C) begin
      errors++;
      $display("FAIL same_cyc10 q=%h exp=13C", bus.q);
    end
  endtask

  task automatic test_priority();
    int n, wl0, iv0, wb0;
    write_set(8'd3, 11'h571);
    read_set(8'd3);
    checks++;
    if (bus.q !== 11'h571) begin
      errors++;
      $display("FAIL pre_rd3 q=%h exp=571", bus.q);
    end
    wl0 = n_wl; iv0 = n_invd; wb0 = n_wb;
    bus.invd_do = 1'b1;
    bus.wb_do   = 1'b1;
    #1;
    checks++;
    if (bus.q !== 11'h000) begin
      errors++;
      $display("FAIL q_start q=%h exp=000", bus.q);
    end
    tick();
    bus.invd_do = 1'b0;
    bus.wb_do   = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.q !== 11'h000) begin
      errors++;
      $display("FAIL q_busy busy=%b q=%h exp 1 000", bus.busy, bus.q);
    end
    wait_idle(n);
    checks++;
    if (n != 256 || n_invd - iv0 != 1 || n_wl != wl0 || n_wb != wb0) begin
      errors++;
      $display("FAIL invd_prio cyc=%0d invd=%0d wl=%0d wb=%0d exp 256 1 0 0",
        n, n_invd - iv0, n_wl - wl0, n_wb - wb0);
    end
    read_set(8'd3);
    checks++;
    if (bus.q !== 11'h000) begin
      errors++;
      $display("FAIL invd_rd3 q=%h exp=000", bus.q);
    end
  endtask

  task automatic test_wbinvd();
    int cyc, wl0, wi0, wb0;
    write_set(8'd3, 11'h571);
    wl0 = n_wl; wi0 = n_wbinvd; wb0 = n_wb;
    bus.wbinvd_do = 1'b1;
    tick();
    bus.wbinvd_do = 1'b0;
    run_sweep(cyc);
    checks++;
    if (cyc != 2050 || n_wl - wl0 != 1 || n_wbinvd - wi0 != 1 ||
        n_wb != wb0) begin
      errors++;
      $display("FAIL wbinvd cyc=%0d wl=%0d done=%0d wb=%0d exp 2050 1 1 0",
        cyc, n_wl - wl0, n_wbinvd - wi0, n_wb - wb0);
    end
    checks++;
    if (wl_addr !== 32'hABCDE030 || wl_line !== {8{16'h0302}}) begin
      errors++;
      $display("FAIL wbinvd_wl addr=%h line=%h exp ABCDE030 0302..",
        wl_addr, wl_line);
    end
    read_set(8'd3);
    checks++;
    if (bus.q !== 11'h000) begin
      errors++;
      $display("FAIL wbinvd_rd3 q=%h exp=000", bus.q);
    end
  endtask

  task automatic test_wb();
    int cyc, wl0, wi0, wb0;
    write_set(8'd3, 11'h571);
    wl0 = n_wl; wi0 = n_wbinvd; wb0 = n_wb;
    bus.wb_do = 1'b1;
    tick();
    bus.wb_do = 1'b0;
    run_sweep(cyc);
    checks++;
    if (cyc != 2050 || n_wl - wl0 != 1 || n_wb - wb0 != 1 ||
        n_wbinvd != wi0 || wl_addr !== 32'hABCDE030) begin
      errors++;
      $display("FAIL wb1 cyc=%0d wl=%0d done=%0d wbinvd=%0d addr=%h exp 2050 1 1 0 ABCDE030",
        cyc, n_wl - wl0, n_wb - wb0, n_wbinvd - wi0, wl_addr);
    end
    read_set(8'd3);
    checks++;
    if (bus.q !== 11'h551) begin
      errors++;
      $display("FAIL wb1_rd3 q=%h exp=551", bus.q);
    end
    wl0 = n_wl; wb0 = n_wb;
    bus.wb_do = 1'b1;
    tick();
    bus.wb_do = 1'b0;
    run_sweep(cyc);
    checks++;
    if (cyc != 2048 || n_wl != wl0 || n_wb - wb0 != 1) begin
      errors++;
      $display("FAIL wb2 cyc=%0d wl=%0d done=%0d exp 2048 0 1",
        cyc, n_wl - wl0, n_wb - wb0);
    end
    read_set(8'd3);
    checks++;
    if (bus.q !== 11'h551) begin
      errors++;
      $display("FAIL wb2_rd3 q=%h exp=551", bus.q);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int n, wl0, wi0;
    write_set(8'd3, 11'h571);
    write_set(8'd200, 11'h7FF);
    wl0 = n_wl; wi0 = n_wbinvd;
    bus.wbinvd_do = 1'b1;
    tick();
    bus.wbinvd_do = 1'b0;
    n = 0;
    while (!bus.writeline_do && n < 3000) begin
      tick();
      n++;
    end
    checks++;
    if (bus.writeline_do !== 1'b1) begin
      errors++;
      $display("FAIL mid_wl_seen wl=%b exp=1", bus.writeline_do);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (bus.writeline_do !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_rst wl=%b busy=%b exp 0 1",
        bus.writeline_do, bus.busy);
    end
    tick();
    rst_n = 1'b1;
    wait_idle(n);
    checks++;
    if (n != 256 || n_wl != wl0 || n_wbinvd != wi0) begin
      errors++;
      $display("FAIL mid_init cyc=%0d wl=%0d done=%0d exp 256 0 0",
        n, n_wl - wl0, n_wbinvd - wi0);
    end
    read_set(8'd3);
    checks++;
    if (bus.q !== 11'h000) begin
      errors++;
      $display("FAIL mid_rd3 q=%h exp=000", bus.q);
    end
    read_set(8'd200);
    checks++;
    if (bus.q !== 11'h000) begin
      errors++;
      $display("FAIL mid_rd200 q=%h exp=000", bus.q);
    end
  endtask

  initial begin
    bus.address        = '0;
    bus.read_do        = 1'b0;
    bus.write_do       = 1'b0;
    bus.data           = '0;
    bus.invd_do        = 1'b0;
    bus.wbinvd_do      = 1'b0;
    bus.wb_do          = 1'b0;
    bus.writeline_done = 1'b0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_priority();
    test_wbinvd();
    test_wb();
    test_reset_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
